// File: rtl/dma_desc_sequencer.sv
// dma_desc_sequencer: descriptor FIFO feeding an AXI4-Lite master that programs
// a DMA engine (SRC, DST, LEN, CTRL), waits for its interrupt, reads STATUS,
// clears the interrupt and emits one completion record per descriptor.
// Optional build macro: DESC_TIMEOUT_EN adds a WAIT_IRQ watchdog that reports 4'hF.
module dma_desc_sequencer #(
  parameter int          QUEUE_DEPTH    = 4,
  parameter logic [31:0] REG_CTRL_OFF   = 32'h00,
  parameter logic [31:0] REG_SRC_OFF    = 32'h04,
  parameter logic [31:0] REG_DST_OFF    = 32'h08,
  parameter logic [31:0] REG_LEN_OFF    = 32'h0C,
  parameter logic [31:0] REG_STAT_OFF   = 32'h10,
  parameter logic [31:0] REG_ICLR_OFF   = 32'h14,
  parameter int          TIMEOUT_CYCLES = 200000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           desc_valid,
  output logic                           desc_ready,
  input  logic [31:0]                    desc_src,
  input  logic [31:0]                    desc_dst,
  input  logic [31:0]                    desc_len,
  output logic                           cmpl_valid,
  input  logic                           cmpl_ready,
  output logic [3:0]                     cmpl_status,
  output logic                           busy,
  output logic [$clog2(QUEUE_DEPTH):0]   q_level,
  input  logic                           intr_pend,
  output logic [31:0]                    m_axil_awaddr,
  output logic                           m_axil_awvalid,
  input  logic                           m_axil_awready,
  output logic [31:0]                    m_axil_wdata,
  output logic [3:0]                     m_axil_wstrb,
  output logic                           m_axil_wvalid,
  input  logic                           m_axil_wready,
  input  logic [1:0]                     m_axil_bresp,
  input  logic                           m_axil_bvalid,
  output logic                           m_axil_bready,
  output logic [31:0]                    m_axil_araddr,
  output logic                           m_axil_arvalid,
  input  logic                           m_axil_arready,
  input  logic [31:0]                    m_axil_rdata,
  input  logic [1:0]                     m_axil_rresp,
  input  logic                           m_axil_rvalid,
  output logic                           m_axil_rready
);

  localparam int PW = $clog2(QUEUE_DEPTH);

  typedef enum logic [3:0] {
    IDLE, WR_SRC, WR_DST, WR_LEN, WR_CTRL, WAIT_IRQ, RD_STAT, WR_ICLR, CMPL
  } state_t;

  localparam logic [3:0] ST_BUS_ERR = 4'hE;

  // descriptor FIFO
  logic [31:0]   fifo_src_q [QUEUE_DEPTH];
  logic [31:0]   fifo_dst_q [QUEUE_DEPTH];
  logic [31:0]   fifo_len_q [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push, pop;

  // sequencer state
  state_t      state_q, state_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic [31:0] dst_q, dst_d, len_q, len_d;
  logic [3:0]  stat_q, stat_d;

  // write launch request decoded by the FSM
  logic        wr_go;
  logic [31:0] wr_addr, wr_data;
  logic        wr_done, b_err;

  // only the low status nibble is meaningful
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^m_axil_rdata[31:4];

  assign desc_ready = (count_q != (PW+1)'(QUEUE_DEPTH));
  assign push       = desc_valid && desc_ready;
  assign q_level    = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

  // FIFO pointer and occupancy update; pointers wrap naturally at the power-of-2 depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are don't-care while their slot is empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_src_q[wr_ptr_q] <= desc_src;
      fifo_dst_q[wr_ptr_q] <= desc_dst;
      fifo_len_q[wr_ptr_q] <= desc_len;
    end
  end

`ifdef DESC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // watchdog counts cycles spent in WAIT_IRQ and sits at zero elsewhere
  always_comb begin
    tmo_d = '0;
    if (state_q == WAIT_IRQ) tmo_d = tmo_q + TW'(1);
  end

  // watchdog register
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // next-state, bus launch and completion-status logic
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q && !m_axil_awready;
    wvalid_d  = wvalid_q  && !m_axil_wready;
    arvalid_d = arvalid_q && !m_axil_arready;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    araddr_d  = araddr_q;
    dst_d     = dst_q;
    len_d     = len_q;
    stat_d    = stat_q;
    pop       = 1'b0;
    wr_go     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    // B is only meaningful once both the address and data handshakes are behind us
    wr_done   = m_axil_bvalid && !awvalid_q && !wvalid_q;
    b_err     = (m_axil_bresp != 2'b00);

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop   = 1'b1;
          dst_d = fifo_dst_q[rd_ptr_q];
          len_d = fifo_len_q[rd_ptr_q];
          if (fifo_len_q[rd_ptr_q] == 32'd0) begin
            stat_d  = 4'h0;
            state_d = CMPL;
          end else begin
            wr_go   = 1'b1;
            wr_addr = REG_SRC_OFF;
            wr_data = fifo_src_q[rd_ptr_q];
            state_d = WR_SRC;
          end
        end
      end
      WR_SRC: begin
        if (wr_done) begin
          if (b_err) begin
            stat_d  = ST_BUS_ERR;
            state_d = CMPL;
          end else begin
            wr_go   = 1'b1;
            wr_addr = REG_DST_OFF;
            wr_data = dst_q;
            state_d = WR_DST;
          end
        end
      end
      WR_DST: begin
        if (wr_done) begin
          if (b_err) begin
            stat_d  = ST_BUS_ERR;
            state_d = CMPL;
          end else begin
            wr_go   = 1'b1;
            wr_addr = REG_LEN_OFF;
            wr_data = len_q;
            state_d = WR_LEN;
          end
        end
      end
      WR_LEN: begin
        if (wr_done) begin
          if (b_err) begin
            stat_d  = ST_BUS_ERR;
            state_d = CMPL;
          end else begin
            wr_go   = 1'b1;
            wr_addr = REG_CTRL_OFF;
            wr_data = 32'h1;
            state_d = WR_CTRL;
          end
        end
      end
      WR_CTRL: begin
        if (wr_done) begin
          if (b_err) begin
            stat_d  = ST_BUS_ERR;
            state_d = CMPL;
          end else begin
            state_d = WAIT_IRQ;
          end
        end
      end
      WAIT_IRQ: begin
        if (intr_pend) begin
          arvalid_d = 1'b1;
          araddr_d  = REG_STAT_OFF;
          state_d   = RD_STAT;
        end
`ifdef DESC_TIMEOUT_EN
        else if (tmo_hit) begin
          stat_d  = 4'hF;
          wr_go   = 1'b1;
          wr_addr = REG_ICLR_OFF;
          wr_data = 32'h1;
          state_d = WR_ICLR;
        end
`endif
      end
      RD_STAT: begin
        if (m_axil_rvalid && !arvalid_q) begin
          if (m_axil_rresp != 2'b00) begin
            stat_d  = ST_BUS_ERR;
            state_d = CMPL;
          end else begin
            stat_d  = m_axil_rdata[3:0];
            wr_go   = 1'b1;
            wr_addr = REG_ICLR_OFF;
            wr_data = 32'h1;
            state_d = WR_ICLR;
          end
        end
      end
      WR_ICLR: begin
        if (wr_done) begin
          if (b_err) stat_d = ST_BUS_ERR;
          state_d = CMPL;
        end
      end
      CMPL: begin
        if (cmpl_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wr_go) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awaddr_d  = wr_addr;
      wdata_d   = wr_data;
    end
  end

  // sequencer and bus registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      stat_q    <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      araddr_q  <= araddr_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      stat_q    <= stat_d;
    end
  end

  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = 4'hF;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = (state_q == WR_SRC) || (state_q == WR_DST) || (state_q == WR_LEN) ||
                          (state_q == WR_CTRL) || (state_q == WR_ICLR);
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = (state_q == RD_STAT);
  assign cmpl_valid     = (state_q == CMPL);
  assign cmpl_status    = stat_q;

endmodule

// File: tb/tb_dma_desc_sequencer.sv
// Directed bench for dma_desc_sequencer with a behavioural AXI4-Lite slave/DMA model.
module tb_dma_desc_sequencer;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [31:0] desc_src = '0, desc_dst = '0, desc_len = '0;
  logic        cmpl_valid;
  logic        cmpl_ready = 1'b0;
  logic [3:0]  cmpl_status;
  logic        busy;
  logic [$clog2(QD):0] q_level;
  logic        intr_pend = 1'b0;
  logic [31:0] m_axil_awaddr;
  logic        m_axil_awvalid;
  logic        m_axil_awready = 1'b0;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid;
  logic        m_axil_wready = 1'b0;
  logic [1:0]  m_axil_bresp = 2'b00;
  logic        m_axil_bvalid = 1'b0;
  logic        m_axil_bready;
  logic [31:0] m_axil_araddr;
  logic        m_axil_arvalid;
  logic        m_axil_arready = 1'b0;
  logic [31:0] m_axil_rdata = '0;
  logic [1:0]  m_axil_rresp = 2'b00;
  logic        m_axil_rvalid = 1'b0;
  logic        m_axil_rready;

  always #5 clk = ~clk;

  dma_desc_sequencer #(.QUEUE_DEPTH(QD), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
    .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready), .cmpl_status(cmpl_status),
    .busy(busy), .q_level(q_level), .intr_pend(intr_pend),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
    .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready)
  );

  // ---------------- scoring ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // ---------------- slave / DMA model configuration (written by stimulus only) ----------------
  int          aw_dly = 0, w_dly = 0, irq_dly = 10;
  logic [3:0]  stat_val = 4'h1;
  bit          berr_on = 0, rerr_on = 0;
  logic [31:0] berr_addr = '0;
  bit          cmpl_hold = 0;

  // ---------------- slave / DMA model state (written by the model only) ----------------
  int          aw_cnt = 0, w_cnt = 0, irq_cnt = 0;
  bit          aw_got = 0, w_got = 0, ar_got = 0, irq_arm = 0, berr_used = 0, rerr_used = 0;
  logic [31:0] aw_addr_l = '0, w_data_l = '0;
  int          extra_hs = 0, rdy_bad = 0, strb_bad = 0, qpeak = 0;
  logic [64:0] log_q[$];   // {is_read, addr, data}
  logic [3:0]  cmpl_q[$];

  // Slave reacts on the falling edge; a ready raised here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
      m_axil_bvalid = 0; m_axil_rvalid = 0; m_axil_bresp = 0; m_axil_rresp = 0;
      aw_got = 0; w_got = 0; ar_got = 0; aw_cnt = 0; w_cnt = 0;
      irq_arm = 0; intr_pend = 0;
      cmpl_ready = !cmpl_hold;
    end else begin
      if (m_axil_bvalid) m_axil_bvalid = 0;
      if (m_axil_rvalid) m_axil_rvalid = 0;
      if (aw_got && w_got) begin
        m_axil_bvalid = 1;
        m_axil_bresp  = (berr_on && !berr_used && aw_addr_l == berr_addr) ? 2'b10 : 2'b00;
        if (m_axil_bresp != 2'b00) berr_used = 1;
        if (!m_axil_bready) rdy_bad++;
        log_q.push_back({1'b0, aw_addr_l, w_data_l});
        if (aw_addr_l == 32'h00 && w_data_l == 32'h1) begin irq_arm = 1; irq_cnt = 0; end
        if (aw_addr_l == 32'h14 && w_data_l == 32'h1) begin irq_arm = 0; intr_pend = 0; end
        aw_got = 0; w_got = 0;
      end
      if (ar_got) begin
        m_axil_rvalid = 1;
        m_axil_rdata  = {28'hABCDEF0, stat_val};
        m_axil_rresp  = (rerr_on && !rerr_used) ? 2'b10 : 2'b00;
        if (m_axil_rresp != 2'b00) rerr_used = 1;
        if (!m_axil_rready) rdy_bad++;
        ar_got = 0;
      end
      m_axil_awready = 0;
      if (m_axil_awvalid) begin
        if (aw_got) extra_hs++;
        else if (aw_cnt >= aw_dly) begin m_axil_awready = 1; aw_got = 1; aw_addr_l = m_axil_awaddr; aw_cnt = 0; end
        else aw_cnt++;
      end
      m_axil_wready = 0;
      if (m_axil_wvalid) begin
        if (m_axil_wstrb != 4'hF) strb_bad++;
        if (w_got) extra_hs++;
        else if (w_cnt >= w_dly) begin m_axil_wready = 1; w_got = 1; w_data_l = m_axil_wdata; w_cnt = 0; end
        else w_cnt++;
      end
      m_axil_arready = 0;
      if (m_axil_arvalid) begin
        if (ar_got || m_axil_rvalid) extra_hs++;
        else begin m_axil_arready = 1; ar_got = 1; log_q.push_back({1'b1, m_axil_araddr, 32'h0}); end
      end
      if (irq_arm && !intr_pend) begin
        irq_cnt++;
        if (irq_cnt >= irq_dly) intr_pend = 1;
      end
      cmpl_ready = !cmpl_hold;
      if (cmpl_valid && cmpl_ready) cmpl_q.push_back(cmpl_status);
      if (int'(q_level) > qpeak) qpeak = int'(q_level);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [64:0] exp_q[$];

  task automatic push_desc(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    int n = 0;
    @(negedge clk);
    desc_valid = 1; desc_src = s; desc_dst = d; desc_len = l;
    while (!desc_ready && n < 4000) begin @(negedge clk); n++; end
    if (n >= 4000) check("push_timeout", 65'(desc_ready), 65'd1);
    @(posedge clk); #1;
    desc_valid = 0;
  endtask

  task automatic exp_full(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    exp_q.push_back({1'b0, 32'h04, s});
    exp_q.push_back({1'b0, 32'h08, d});
    exp_q.push_back({1'b0, 32'h0C, l});
    exp_q.push_back({1'b0, 32'h00, 32'h1});
    exp_q.push_back({1'b1, 32'h10, 32'h0});
    exp_q.push_back({1'b0, 32'h14, 32'h1});
  endtask

  task automatic expect_log(input string tag, input int base);
    check({tag, "_ntxn"}, 65'(log_q.size() - base), 65'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < log_q.size()) check($sformatf("%s_txn%0d", tag, i), log_q[base + i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic wait_done(input string tag, input int cbase, input int n);
    int k = 0;
    while ((cmpl_q.size() < cbase + n || busy) && k < 4000) begin @(negedge clk); k++; end
    check({tag, "_done"}, 65'(k < 4000), 65'd1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int lb, cb, k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready, cmpl_valid}, 0);
    check("rst_addr_data", {m_axil_awaddr, m_axil_wdata}, 0);
    check("rst_araddr", m_axil_araddr, 0);
    check("rst_status_level", {cmpl_status, q_level, busy}, 0);
    check("rst_desc_ready", desc_ready, 1);
    rst = 0;
    repeat (2) @(negedge clk);

    // single descriptor, zero-wait slave
    lb = log_q.size(); cb = cmpl_q.size();
    stat_val = 4'h1; irq_dly = 10;
    push_desc(32'h1000, 32'h2000, 32'd64);
    wait_done("t1", cb, 1);
    check("t1_status", cmpl_q[cb], 4'h1);
    exp_full(32'h1000, 32'h2000, 32'd64);
    expect_log("t1", lb);

    // five back-to-back descriptors against a depth-4 queue
    lb = log_q.size(); cb = cmpl_q.size();
    stat_val = 4'h3;
    for (int i = 0; i < 5; i++) push_desc(32'h100 * (i + 1), 32'hA000 + 32'h10 * i, 32'd4 + i);
    check("t2_full_ready", desc_ready, 0);
    check("t2_full_level", q_level, 4);
    wait_done("t2", cb, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_status%0d", i), cmpl_q[cb + i], 4'h3);
      exp_full(32'h100 * (i + 1), 32'hA000 + 32'h10 * i, 32'd4 + i);
    end
    expect_log("t2", lb);
    check("t2_qpeak", qpeak, 4);

    // skewed address vs data ready, both directions
    lb = log_q.size(); cb = cmpl_q.size();
    stat_val = 4'h5; aw_dly = 3; w_dly = 0;
    push_desc(32'h3000, 32'h4000, 32'd128);
    wait_done("t3a", cb, 1);
    aw_dly = 0; w_dly = 3;
    push_desc(32'h3100, 32'h4100, 32'd256);
    wait_done("t3b", cb, 2);
    w_dly = 0;
    check("t3_status_a", cmpl_q[cb], 4'h5);
    check("t3_status_b", cmpl_q[cb + 1], 4'h5);
    exp_full(32'h3000, 32'h4000, 32'd128);
    exp_full(32'h3100, 32'h4100, 32'd256);
    expect_log("t3", lb);
    check("t3_extra_handshakes", extra_hs, 0);

    // write error on DST aborts the descriptor; the next one runs normally
    lb = log_q.size(); cb = cmpl_q.size();
    stat_val = 4'h2; berr_addr = 32'h08; berr_on = 1;
    push_desc(32'h5000, 32'h6000, 32'd32);
    push_desc(32'h5100, 32'h6100, 32'd48);
    wait_done("t4", cb, 2);
    check("t4_status_err", cmpl_q[cb], 4'hE);
    check("t4_status_next", cmpl_q[cb + 1], 4'h2);
    exp_q.push_back({1'b0, 32'h04, 32'h5000});
    exp_q.push_back({1'b0, 32'h08, 32'h6000});
    exp_full(32'h5100, 32'h6100, 32'd48);
    expect_log("t4", lb);

    // zero-length descriptor with the completion held off
    lb = log_q.size(); cb = cmpl_q.size();
    stat_val = 4'h7; cmpl_hold = 1;
    push_desc(32'h7000, 32'h8000, 32'd0);
    push_desc(32'h7100, 32'h8100, 32'd16);
    repeat (20) @(negedge clk);
    check("t5_hold_valid", cmpl_valid, 1);
    check("t5_hold_status", cmpl_status, 4'h0);
    check("t5_hold_level", q_level, 1);
    check("t5_hold_no_bus", 65'(log_q.size() - lb), 0);
    cmpl_hold = 0;
    wait_done("t5", cb, 2);
    check("t5_status_zero", cmpl_q[cb], 4'h0);
    check("t5_status_next", cmpl_q[cb + 1], 4'h7);
    exp_full(32'h7100, 32'h8100, 32'd16);
    expect_log("t5", lb);

    // read error on STATUS: ICLR is skipped, status reports a bus error
    lb = log_q.size(); cb = cmpl_q.size();
    rerr_on = 1;
    push_desc(32'h9000, 32'h9800, 32'd8);
    wait_done("t6", cb, 1);
    check("t6_status", cmpl_q[cb], 4'hE);
    exp_full(32'h9000, 32'h9800, 32'd8);
    void'(exp_q.pop_back());
    expect_log("t6", lb);

    // reset in the middle of a transfer
    irq_dly = 10;
    push_desc(32'hB000, 32'hC000, 32'd40);
    push_desc(32'hB100, 32'hC100, 32'd44);
    k = 0;
    while (!m_axil_awvalid && k < 200) begin @(negedge clk); k++; end
    check("t7_saw_write", m_axil_awvalid, 1);
    rst = 1;
    @(posedge clk); #1;
    check("t7_valids_dropped", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 0);
    check("t7_queue_flushed", {q_level, busy}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    lb = log_q.size(); cb = cmpl_q.size();
    stat_val = 4'h9;
    push_desc(32'hD000, 32'hE000, 32'd12);
    wait_done("t7", cb, 1);
    check("t7_status", cmpl_q[cb], 4'h9);
    exp_full(32'hD000, 32'hE000, 32'd12);
    expect_log("t7", lb);

`ifdef DESC_TIMEOUT_EN
    // interrupt never arrives: watchdog clears the interrupt and reports a timeout
    lb = log_q.size(); cb = cmpl_q.size();
    irq_dly = 1000000;
    push_desc(32'hF000, 32'hF800, 32'd20);
    wait_done("t8", cb, 1);
    check("t8_status", cmpl_q[cb], 4'hF);
    exp_full(32'hF000, 32'hF800, 32'd20);
    exp_q.delete(4);
    expect_log("t8", lb);
`endif

    check("ready_protocol", rdy_bad, 0);
    check("wstrb_all_ones", strb_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dma_desc_sequencer.md
Name: dma_desc_sequencer

Overview:
Descriptor-queue front end for axi_dma_subsystem; sits directly upstream of its AXI4-Lite config port and drives it as an AXI4-Lite master.
Accepts {src, dst, len} descriptors into a FIFO, programs SRC/DST/LEN/CTRL, waits for intr_pend, reads STATUS, clears the interrupt and emits one completion per descriptor.
Lets software or a higher-level engine queue back-to-back transfers without polling.

Parameters:
QUEUE_DEPTH, 4, descriptor FIFO entries (power of 2, >=2)
REG_CTRL_OFF, 32'h00, CTRL register offset; write 32'h1 = start
REG_SRC_OFF, 32'h04, source address register offset
REG_DST_OFF, 32'h08, destination address register offset
REG_LEN_OFF, 32'h0C, length (bytes) register offset
REG_STAT_OFF, 32'h10, status register offset; bits[3:0] = completion status
REG_ICLR_OFF, 32'h14, interrupt clear offset; write 32'h1 clears intr_pend
TIMEOUT_CYCLES, 200000, WAIT_IRQ watchdog limit (used only with DESC_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
desc_valid  in  1  descriptor offered
desc_ready  out  1  FIFO not full
desc_src  in  32  source address
desc_dst  in  32  destination address
desc_len  in  32  length in bytes
cmpl_valid  out  1  completion record valid
cmpl_ready  in  1  completion accepted
cmpl_status  out  4  STATUS[3:0], 4'hE = bus error, 4'hF = timeout
busy  out  1  FSM not IDLE or FIFO not empty
q_level  out  $clog2(QUEUE_DEPTH)+1  FIFO occupancy
intr_pend  in  1  DMA interrupt pending
m_axil_awaddr/awvalid/awready  out/out/in  32/1/1  write address channel
m_axil_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  write data channel; wstrb always 4'hF
m_axil_bresp/bvalid/bready  in/in/out  2/1/1  write response channel
m_axil_araddr/arvalid/arready  out/out/in  32/1/1  read address channel
m_axil_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data channel

Behaviour:
- Reset: all valids 0, bready/rready 0, addresses/data 0, cmpl_status 0, FIFO empty, q_level 0, FSM IDLE. A mid-transfer reset drops all AXI valids on the next edge and discards queued descriptors.
- FIFO: push on desc_valid&&desc_ready; desc_ready = !full. Simultaneous push/pop when full is not allowed (ready low). Pointers wrap modulo QUEUE_DEPTH.
- FSM states: IDLE, WR_SRC, WR_DST, WR_LEN, WR_CTRL, WAIT_IRQ, RD_STAT, WR_ICLR, CMPL.
- IDLE, FIFO non-empty: pop into holding registers. len==0 -> CMPL with status 4'h0, no bus traffic. Otherwise -> WR_SRC.
- Write states: assert awvalid and wvalid together in the state's first cycle. Each valid drops independently on its own handshake; address/data stay stable while valid. bready=1 throughout. Advance on bvalid, only after both handshakes are done.
- Write order: SRC -> DST -> LEN -> CTRL(32'h1) -> WAIT_IRQ.
- WAIT_IRQ: stay until intr_pend==1 -> RD_STAT.
- RD_STAT: arvalid until arready; rready=1; on rvalid capture rdata[3:0] -> WR_ICLR (writes 32'h1).
- Bus errors: any bresp/rresp != 2'b00 -> finish the current transaction, then CMPL with status 4'hE. Remaining writes are skipped; CTRL is never written after an earlier error. An error on the ICLR write also reports 4'hE.
- CMPL: cmpl_valid held until cmpl_ready, then IDLE. The next descriptor is popped no earlier than the cycle after acceptance.
- Never more than one outstanding AXI-Lite transaction.
- Minimum latency, zero-wait slave: FIFO pop to cmpl_valid = 6 transactions x 2 cycles + intr wait + 2.

Optional Feature:
DESC_TIMEOUT_EN: a counter clears on WAIT_IRQ entry and increments each cycle there. On reaching TIMEOUT_CYCLES it skips RD_STAT and issues the ICLR write, then CMPL with status 4'hF. Without the macro there is no counter, WAIT_IRQ waits indefinitely, and 4'hF is never produced.

Test Plan:
1. One descriptor {0x1000, 0x2000, 64}, zero-wait slave; intr 10 cycles after CTRL, STATUS=4'h1 -> writes to 0x04/0x08/0x0C/0x00 in that order with data 0x1000/0x2000/64/1, read 0x10, write 0x14=1; cmpl_status=4'h1.
2. Push 5 descriptors back-to-back, QUEUE_DEPTH=4 -> desc_ready low after 4 are queued; all 5 complete in order; q_level peaks at 4.
3. awready delayed 3 cycles vs wready, and the reverse -> valids drop independently, exactly one B per write, sequence unchanged.
4. bresp=2'b10 on the DST write -> LEN/CTRL not issued; cmpl_status=4'hE; next descriptor proceeds normally.
5. desc_len=0 -> no AXI activity; cmpl_status=4'h0. Holding cmpl_ready low 20 cycles -> cmpl_valid held and no new pop.
6. (DESC_TIMEOUT_EN, TIMEOUT_CYCLES=50) intr_pend never asserts -> ICLR written after 50 cycles; cmpl_status=4'hF.
